uart_msg_streamer: RTL

Parametrised message transmitter that drives the byte-side interface of the `uart` core (`transmit`, `tx_byte`, `is_transmitting`). It streams a fixed ROM message byte by byte and paces each byte on the UART busy handshake rather than a free-running counter. The message can be sent once per trigger or repeated with a programmable idle gap. It sits between application logic and `uart`, replacing hand-timed transmit loops.

---
 rtl/uart_msg_streamer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_msg_streamer.sv
// Streams a MSG_INIT byte ROM to a uart byte port, pacing each byte on the tx_busy handshake; UART_MSG_ECHO_EN adds rx echo insertion.
// First strobe 2 cycles after trigger, 2 cycles per byte after tx_busy falls; a strobe is never withdrawn and tx_byte never changes mid-byte.
module uart_msg_streamer #(
   parameter int unsigned          MSG_LEN      = 14,
   parameter logic [8*MSG_LEN-1:0] MSG_INIT     = "Hello, world!\n",
   parameter bit                   REPEAT       = 1'b1,
   parameter int unsigned          GAP_CYCLES   = 12000000,
   parameter int unsigned          BUSY_TIMEOUT = 4,
   localparam int unsigned         IDX_W        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic             tx_busy_i,
   input  logic             rx_valid_i,
   input  logic [7:0]       rx_data_i,
   output logic             transmit_o,
   output logic [7:0]       tx_byte_o,
   output logic [IDX_W-1:0] index_o,
   output logic             active_o,
   output logic             msg_done_o,
   output logic             busy_timeout_o,
   output logic             echo_overflow_o
);
   localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned BT_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [BT_W-1:0]  BT_LAST  = BT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   typedef enum logic [2:0] {IDLE, LOAD, PULSE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             transmit_q, active_q, msg_done_q, msg_done_d;
   logic             busy_to_q, busy_to_d;
   logic [BT_W-1:0]  bc_q, bc_d;
   logic [GAP_W-1:0] gc_q, gc_d;
   logic             trigger, gap_done, last_byte;

   // First character of MSG_INIT is ROM[0].
   logic [7:0] rom [MSG_LEN];
   for (genvar g = 0; g < MSG_LEN; g++) begin : g_rom
      assign rom[g] = MSG_INIT[8*(MSG_LEN-1-g) +: 8];
   end

   assign trigger   = enable_i && (REPEAT || start_i);
   assign gap_done  = (gc_q == GAP_LAST);
   assign last_byte = (index_q == IDX_LAST);

`ifdef UART_MSG_ECHO_EN
   logic [7:0] echo_q, echo_d;
   logic       pend_q, pend_d, ovf_q, ovf_d, is_echo_q, is_echo_d;
   state_t     ret_q, ret_d;
`endif

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      tx_byte_d  = tx_byte_q;
      msg_done_d = 1'b0;
      busy_to_d  = busy_to_q;
      bc_d       = bc_q;
      gc_d       = gc_q;
`ifdef UART_MSG_ECHO_EN
      echo_d     = echo_q;
      pend_d     = pend_q;
      ovf_d      = ovf_q;
      is_echo_d  = is_echo_q;
      ret_d      = ret_q;
`endif
      unique case (state_q)
         IDLE: begin
            index_d = '0;
            if (trigger) state_d = LOAD;
`ifdef UART_MSG_ECHO_EN
            else if (pend_q) state_d = LOAD;
`endif
         end
         LOAD: begin
            state_d   = PULSE;
            bc_d      = '0;
            tx_byte_d = rom[index_q];
`ifdef UART_MSG_ECHO_EN
            is_echo_d = pend_q;
            if (pend_q) begin
               tx_byte_d = echo_q;
               pend_d    = 1'b0;
            end
`endif
         end
         PULSE: state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = WAIT_DONE;
            end else if (bc_q == BT_LAST) begin
               busy_to_d = 1'b1;
               state_d   = WAIT_DONE;
            end else begin
               bc_d = bc_q + BT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy_i) begin
`ifdef UART_MSG_ECHO_EN
               if (is_echo_q) state_d = ret_q;
               else
`endif
               if (!last_byte) begin
                  index_d = enable_i ? index_q + IDX_W'(1) : '0;
                  state_d = enable_i ? LOAD : IDLE;
               end else begin
                  msg_done_d = 1'b1;
                  index_d    = '0;
                  if (REPEAT && enable_i) begin
                     state_d = (GAP_CYCLES > 0) ? GAP : LOAD;
                     gc_d    = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         GAP: begin
            if (!enable_i) state_d = IDLE;
            else if (gap_done) state_d = LOAD;
`ifdef UART_MSG_ECHO_EN
            else if (pend_q) state_d = LOAD;
`endif
            else gc_d = gc_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
`ifdef UART_MSG_ECHO_EN
      // An echo-only excursion from IDLE or GAP returns there; anything else resumes the message.
      if (state_d == LOAD && state_q != WAIT_DONE)
         ret_d = (state_q == IDLE && !trigger) ? IDLE :
                 (state_q == GAP && !gap_done) ? GAP : LOAD;
      if (rx_valid_i) begin
         if (pend_d) begin
            ovf_d = 1'b1;
         end else begin
            echo_d = rx_data_i;
            pend_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         index_q    <= '0;
         tx_byte_q  <= 8'h00;
         transmit_q <= 1'b0;
         active_q   <= 1'b0;
         msg_done_q <= 1'b0;
         busy_to_q  <= 1'b0;
         bc_q       <= '0;
         gc_q       <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         tx_byte_q  <= tx_byte_d;
         transmit_q <= (state_d == PULSE);
         active_q   <= (state_d != IDLE);
         msg_done_q <= msg_done_d;
         busy_to_q  <= busy_to_d;
         bc_q       <= bc_d;
         gc_q       <= gc_d;
      end
   end

`ifdef UART_MSG_ECHO_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         echo_q    <= 8'h00;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         is_echo_q <= 1'b0;
         ret_q     <= IDLE;
      end else begin
         echo_q    <= echo_d;
         pend_q    <= pend_d;
         ovf_q     <= ovf_d;
         is_echo_q <= is_echo_d;
         ret_q     <= ret_d;
      end
   end
   assign echo_overflow_o = ovf_q;
`else
   logic unused_rx;
   assign unused_rx       = ^{rx_valid_i, rx_data_i};
   assign echo_overflow_o = 1'b0;
`endif

   assign transmit_o     = transmit_q;
   assign tx_byte_o      = tx_byte_q;
   assign index_o        = index_q;
   assign active_o       = active_q;
   assign msg_done_o     = msg_done_q;
   assign busy_timeout_o = busy_to_q;
endmodule
